// File: rtl/mips_pkg.sv
// Shared definitions for the serial program loader that feeds the MIPS core's IMEM.
package mips_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } loader_state_t;

  // Frame layout: 2 length bytes, N*4 data bytes, 1 checksum byte.
  localparam int HDR_LEN        = 2;
  localparam int CSUM_LEN       = 1;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_if.sv
// Host byte link and IMEM write port of the boot loader.
interface boot_loader_if;
  // Handshake: a byte moves on every rising clk where rx_valid && rx_ready are both 1;
  // the host holds rx_data stable while rx_valid is high and not yet accepted.
  // imem_we is a single-cycle strobe qualifying imem_addr/imem_wdata, with no back-pressure.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/word_assembler.sv
// Packs four big-endian bytes into a 32-bit word; word_valid fires with the 4th byte.
module word_assembler
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt;
  // Only the first three bytes need storage; the 4th is taken straight from byte_in.
  logic [23:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      shift    <= 24'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= {shift[15:0], byte_in};
    end
  end

  assign word_valid = byte_en && (byte_cnt == LAST_BYTE);
  assign word       = {shift, byte_in};

endmodule

// File: rtl/boot_loader.sv
// Frame parser that writes a checksummed program image into IMEM and then releases the core.
module boot_loader
  import mips_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          core_nrst,
  output logic          done,
  output logic          error,
  output loader_state_t state_dbg
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t state, state_next;
  logic [15:0]   len;
  logic [15:0]   word_cnt;
  logic [7:0]    sum;
  logic [15:0]   len_rx;
  logic          xfer;
  logic          byte_en;
  logic          word_valid;
  logic [31:0]   word;

  assign xfer      = bus.rx_valid && bus.rx_ready;
  assign byte_en   = xfer && (state == S_DATA);
  assign len_rx    = {len[15:8], bus.rx_data};
  assign state_dbg = state;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: if (xfer) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_rx == 16'd0 || {1'b0, len_rx} > MAX_N) state_next = S_ERR;
          else                                           state_next = S_DATA;
        end
      end
      S_DATA:   if (word_valid && word_cnt == len - 16'd1) state_next = S_CSUM;
      S_CSUM: begin
        if (xfer) begin
          if (bus.rx_data == sum) state_next = S_RUN;
          else                    state_next = S_ERR;
        end
      end
      default:  state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_LEN_HI;
      len            <= 16'd0;
      word_cnt       <= 16'd0;
      sum            <= 8'd0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= 32'd0;
      core_nrst      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer && state == S_LEN_HI) len[15:8] <= bus.rx_data;
      if (xfer && state == S_LEN_LO) len[7:0]  <= bus.rx_data;
      // The checksum byte itself is not part of the sum it is compared against.
      if (xfer && state != S_CSUM) sum <= sum + bus.rx_data;

      bus.imem_we <= word_valid;
      if (word_valid) begin
        bus.imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
        bus.imem_wdata <= word;
        word_cnt       <= word_cnt + 16'd1;
      end

      bus.rx_ready <= (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                      (state_next == S_DATA)   || (state_next == S_CSUM);
      core_nrst    <= (state_next == S_RUN);
      done         <= (state_next == S_RUN);
      error        <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances, default base address and BASE_ADDR=0x100.
module tb_boot_loader;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  boot_loader_if bif_a ();
  boot_loader_if bif_b ();

  logic          core_nrst_a, done_a, error_a;
  logic          core_nrst_b, done_b, error_b;
  loader_state_t state_a, state_b;

  boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif_a),
    .core_nrst (core_nrst_a),
    .done      (done_a),
    .error     (error_a),
    .state_dbg (state_a)
  );

  boot_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif_b),
    .core_nrst (core_nrst_b),
    .done      (done_b),
    .error     (error_b),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_a[$];
  logic [63:0] got_b[$];
  int          t_a[$];
  logic [7:0]  tx_q[$];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (bif_a.imem_we === 1'b1) begin
      got_a.push_back({bif_a.imem_addr, bif_a.imem_wdata});
      t_a.push_back(cycle);
    end
    if (bif_b.imem_we === 1'b1) got_b.push_back({bif_b.imem_addr, bif_b.imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input bit which, input logic [7:0] b);
    int   waitn;
    logic rdy;
    waitn = 0;
    @(negedge clk);
    if (which) begin bif_b.rx_data = b; bif_b.rx_valid = 1'b1; end
    else       begin bif_a.rx_data = b; bif_a.rx_valid = 1'b1; end
    rdy = which ? bif_b.rx_ready : bif_a.rx_ready;
    while (rdy !== 1'b1 && waitn < 20) begin
      @(negedge clk);
      waitn++;
      rdy = which ? bif_b.rx_ready : bif_a.rx_ready;
    end
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: rx_ready=%b after %0d cycles, required 1", rdy, waitn);
    end
    @(posedge clk);
    #1;
    if (which) bif_b.rx_valid = 1'b0;
    else       bif_a.rx_valid = 1'b0;
  endtask

  task automatic send_q(input bit which);
    while (tx_q.size() > 0) send_byte(which, tx_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_a.delete();
    got_b.delete();
    t_a.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bif_a.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b required 0", bif_a.rx_ready); end
    n_checks++; if (bif_a.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_imem_we: got %b required 0", bif_a.imem_we); end
    n_checks++; if (bif_a.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr_a: got %h required 00000000", bif_a.imem_addr); end
    n_checks++; if (bif_b.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr_b: got %h required 00000100", bif_b.imem_addr); end
    n_checks++; if (bif_a.imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h required 00000000", bif_a.imem_wdata); end
    n_checks++; if ({core_nrst_a, done_a, error_a} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b required 000", {core_nrst_a, done_a, error_a}); end
    n_checks++; if (state_a !== S_LEN_HI) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", state_a, S_LEN_HI); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bif_a.rx_ready !== 1'b1 || bif_b.rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b%b required 11", bif_a.rx_ready, bif_b.rx_ready); end
    got_a.delete(); got_b.delete(); t_a.delete();
  endtask

  task automatic test_normal_load();
    do_reset();
    // 0x00+0x02+0x20+0x08+0x00+0x05+0x00+0x00+0x00+0x0D = 0x3C
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D};
    send_q(1'b0);
    n_checks++; if (core_nrst_a !== 1'b0 || state_a !== S_CSUM) begin n_fail++; $display("FAIL normal_pre_csum: nrst=%b state=%0d required 0/%0d", core_nrst_a, state_a, S_CSUM); end
    send_byte(1'b0, 8'h3C);
    n_checks++; if ({core_nrst_a, done_a, error_a} !== 3'b110) begin n_fail++; $display("FAIL normal_status: got %b required 110", {core_nrst_a, done_a, error_a}); end
    exp_q = '{{32'h0, 32'h2008_0005}, {32'h4, 32'h0000_000D}};
    n_checks++; if (got_a.size() !== exp_q.size()) begin n_fail++; $display("FAIL normal_write_count: got %0d required %0d", got_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      n_checks++; if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL normal_write%0d: got %h required %h", i, got_a[i], exp_q[i]); end
    end
    if (t_a.size() == 2) begin
      n_checks++; if (t_a[1] - t_a[0] !== 4) begin n_fail++; $display("FAIL normal_spacing: got %0d cycles required 4", t_a[1] - t_a[0]); end
    end
    @(negedge clk);
    n_checks++; if (bif_a.rx_ready !== 1'b0) begin n_fail++; $display("FAIL normal_ready_after: got %b required 0", bif_a.rx_ready); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h3D};
    send_q(1'b0);
    n_checks++; if ({core_nrst_a, done_a, error_a} !== 3'b001) begin n_fail++; $display("FAIL badcs_status: got %b required 001", {core_nrst_a, done_a, error_a}); end
    n_checks++; if (got_a.size() !== 2) begin n_fail++; $display("FAIL badcs_write_count: got %0d required 2", got_a.size()); end
    @(negedge clk);
    bif_a.rx_valid = 1'b1; bif_a.rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++; if (bif_a.rx_ready !== 1'b0 || state_a !== S_ERR) begin n_fail++; $display("FAIL badcs_stall: ready=%b state=%0d required 0/%0d", bif_a.rx_ready, state_a, S_ERR); end
    n_checks++; if (core_nrst_a !== 1'b0 || error_a !== 1'b1) begin n_fail++; $display("FAIL badcs_sticky: nrst=%b err=%b required 0/1", core_nrst_a, error_a); end
    bif_a.rx_valid = 1'b0;
  endtask

  task automatic test_len_reject();
    do_reset();
    tx_q = '{8'h00, 8'h00};
    send_q(1'b0);
    n_checks++; if (error_a !== 1'b1 || state_a !== S_ERR) begin n_fail++; $display("FAIL len0_error: err=%b state=%0d required 1/%0d", error_a, state_a, S_ERR); end
    @(negedge clk);
    n_checks++; if (got_a.size() !== 0) begin n_fail++; $display("FAIL len0_writes: got %0d required 0", got_a.size()); end

    do_reset();
    tx_q = '{8'h01, 8'h01};
    send_q(1'b0);
    n_checks++; if (error_a !== 1'b1) begin n_fail++; $display("FAIL len257_error: got %b required 1", error_a); end
    @(negedge clk);
    n_checks++; if (got_a.size() !== 0) begin n_fail++; $display("FAIL len257_writes: got %0d required 0", got_a.size()); end

    do_reset();
    tx_q = '{8'h01, 8'h00};
    send_q(1'b0);
    n_checks++; if (error_a !== 1'b0 || state_a !== S_DATA) begin n_fail++; $display("FAIL len256_accept: err=%b state=%0d required 0/%0d", error_a, state_a, S_DATA); end
  endtask

  task automatic test_gaps();
    do_reset();
    // 0x01+0x12+0x34+0x56+0x78 = 0x115 -> 0x15
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_q(1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (got_a.size() !== 0 || state_a !== S_DATA) begin n_fail++; $display("FAIL gap_hold: writes=%0d state=%0d required 0/%0d", got_a.size(), state_a, S_DATA); end
    tx_q = '{8'h56, 8'h78, 8'h15};
    send_q(1'b0);
    n_checks++; if (got_a.size() !== 1) begin n_fail++; $display("FAIL gap_write_count: got %0d required 1", got_a.size()); end
    else begin
      n_checks++; if (got_a[0] !== {32'h0, 32'h1234_5678}) begin n_fail++; $display("FAIL gap_write: got %h required %h", got_a[0], {32'h0, 32'h1234_5678}); end
    end
    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b required 1", done_a); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    tx_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_q(1'b0);
    @(negedge clk);
    n_checks++; if (got_a.size() !== 1) begin n_fail++; $display("FAIL mid_first_write: got %0d required 1", got_a.size()); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (core_nrst_a !== 1'b0 || state_a !== S_LEN_HI) begin n_fail++; $display("FAIL mid_reset: nrst=%b state=%0d required 0/%0d", core_nrst_a, state_a, S_LEN_HI); end
    rst = 1'b0;
    @(negedge clk);
    got_a.delete(); t_a.delete();
    // 0x01+0xAA+0xBB+0xCC+0xDD = 0x30F -> 0x0F
    tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F};
    send_q(1'b0);
    n_checks++; if (got_a.size() !== 1) begin n_fail++; $display("FAIL mid_write_count: got %0d required 1", got_a.size()); end
    else begin
      n_checks++; if (got_a[0] !== {32'h0, 32'hAABB_CCDD}) begin n_fail++; $display("FAIL mid_write: got %h required %h", got_a[0], {32'h0, 32'hAABB_CCDD}); end
    end
    n_checks++; if (done_a !== 1'b1 || core_nrst_a !== 1'b1) begin n_fail++; $display("FAIL mid_done: done=%b nrst=%b required 1/1", done_a, core_nrst_a); end
  endtask

  task automatic test_base_addr();
    do_reset();
    // 0x03 + 4*0x11 + 4*0x22 + 0x0D = 0xDC
    tx_q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h00, 8'h00, 8'h00, 8'h0D, 8'hDC};
    send_q(1'b1);
    exp_q = '{{32'h100, 32'h1111_1111}, {32'h104, 32'h2222_2222}, {32'h108, 32'h0000_000D}};
    n_checks++; if (got_b.size() !== exp_q.size()) begin n_fail++; $display("FAIL base_write_count: got %0d required %0d", got_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      n_checks++; if (got_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL base_write%0d: got %h required %h", i, got_b[i], exp_q[i]); end
    end
    n_checks++; if (done_b !== 1'b1 || core_nrst_b !== 1'b1) begin n_fail++; $display("FAIL base_done: done=%b nrst=%b required 1/1", done_b, core_nrst_b); end
    @(negedge clk);
    bif_b.rx_valid = 1'b1; bif_b.rx_data = 8'h55;
    repeat (3) @(negedge clk);
    n_checks++; if (bif_b.rx_ready !== 1'b0 || state_b !== S_RUN) begin n_fail++; $display("FAIL base_stall: ready=%b state=%0d required 0/%0d", bif_b.rx_ready, state_b, S_RUN); end
    n_checks++; if (got_b.size() !== 3) begin n_fail++; $display("FAIL base_no_extra: got %0d writes required 3", got_b.size()); end
    bif_b.rx_valid = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bif_a.rx_valid = 1'b0; bif_a.rx_data = 8'h00;
    bif_b.rx_valid = 1'b0; bif_b.rx_data = 8'h00;
    test_reset();
    test_normal_load();
    test_bad_csum();
    test_len_reject();
    test_gaps();
    test_reset_mid_frame();
    test_base_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
